// File: rtl/compute_engine_16_pkg.sv
// Package: compute_engine_16_pkg
// Shared widths, the latency tag type and signed-arithmetic helpers for the
// compute_engine_16 datapath blocks.
//   ACT_W  - activation operand width (signed)
//   WGT_W  - weight operand width (signed)
//   PROD_W - multiplier product width (signed)
package compute_engine_16_pkg;

    localparam int unsigned ACT_W  = 16;
    localparam int unsigned WGT_W  = 8;
    localparam int unsigned PROD_W = 24;

    // One slot of the multiplier latency tracker.
    typedef struct packed {
        logic valid;
        logic last;
    } tag_t;

    // Two's-complement add overflow: both operands share a sign and the
    // result sign differs from it.
    function automatic logic add_overflow(input logic a_sign,
                                          input logic b_sign,
                                          input logic s_sign);
        return (a_sign == b_sign) && (s_sign != a_sign);
    endfunction

    // Clamp value for a signed field of the given width (1..64). The result
    // is sign-extended to 64 bits so callers can size-cast it to their width.
    // neg = 1 selects the most negative value, otherwise the most positive.
    function automatic logic [63:0] sat_bound(input logic        neg,
                                              input int unsigned width);
        logic [63:0] max_pos;
        max_pos = {64{1'b1}} >> (65 - width);
        return neg ? ~max_pos : max_pos;
    endfunction

endpackage

// File: rtl/compute_engine_16_lat_tag.sv
// Module: compute_engine_16_lat_tag
// Clock-enable gated shift register of {valid, last} tags that mirrors the
// pipeline depth of the external multiplier, so the tail slot lines up with
// the product currently on the multiplier output.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   ce                    - shift enable (same enable as the multiplier)
//   in_valid, in_last     - tag entering stage 0
//   tail_valid, tail_last - tag at the final stage
module compute_engine_16_lat_tag
    import compute_engine_16_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic ce,
    input  logic in_valid,
    input  logic in_last,
    output logic tail_valid,
    output logic tail_last
);

    tag_t [DEPTH-1:0] pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe <= '0;
        end else if (ce) begin
            // last is only meaningful alongside valid; bubbles carry 0.
            pipe[0] <= '{valid: in_valid, last: in_valid && in_last};
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign tail_valid = pipe[DEPTH-1].valid;
    assign tail_last  = pipe[DEPTH-1].last;

endmodule

// File: rtl/compute_engine_16_mac_feeder.sv
// Module: compute_engine_16_mac_feeder
// Feeds (activation, weight) pairs into an external pipelined 16s x 8s -> 24s
// multiplier, tracks its latency with a tag pipe, accumulates products per
// vector and presents one signed dot-product per vector through a
// single-entry output holding register.
// Ports:
//   clk, reset                      - clock, synchronous active-high reset
//   in_valid/in_ready               - operand pair handshake
//   in_act, in_wgt, in_last         - signed operands, end-of-vector marker
//   mul_ce, mul_din0, mul_din1      - multiplier enable and operands
//   mul_dout                        - multiplier product
//   out_valid/out_ready             - result handshake
//   out_data, out_count, out_ovf    - dot-product, product count, overflow
module compute_engine_16_mac_feeder
    import compute_engine_16_pkg::*;
#(
    parameter int unsigned MUL_LAT  = 3,
    parameter int unsigned ACC_W    = 32,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ACT_W-1:0]        in_act,
    input  logic [WGT_W-1:0]        in_wgt,
    input  logic                    in_last,
    output logic                    mul_ce,
    output logic [ACT_W-1:0]        mul_din0,
    output logic [WGT_W-1:0]        mul_din1,
    input  logic [PROD_W-1:0]       mul_dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0]        out_count,
    output logic                    out_ovf
);

    logic                    stall;
    logic                    accept;
    logic                    tail_valid;
    logic                    tail_last;
    logic                    step;

    logic signed [ACC_W-1:0] acc;
    logic [CNT_W-1:0]        cnt;
    logic                    ovf_acc;

    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] sum_raw;
    logic signed [ACC_W-1:0] sum;
    logic                    ovf;

    // Only a finished vector that cannot be handed off blocks progress; the
    // multiplier and tag pipe freeze together so the tail product stays put.
    assign stall    = out_valid && !out_ready && tail_valid && tail_last;
    assign mul_ce   = !stall;
    assign in_ready = mul_ce;
    assign accept   = in_valid && in_ready;

    assign mul_din0 = in_act;
    assign mul_din1 = in_wgt;

    compute_engine_16_lat_tag #(
        .DEPTH (MUL_LAT)
    ) u_lat_tag (
        .clk        (clk),
        .reset      (reset),
        .ce         (mul_ce),
        .in_valid   (accept),
        .in_last    (in_last),
        .tail_valid (tail_valid),
        .tail_last  (tail_last)
    );

    assign step = mul_ce && tail_valid;

    always_comb begin
        prod_ext = ACC_W'($signed(mul_dout));
        sum_raw  = acc + prod_ext;
        ovf      = add_overflow(acc[ACC_W-1], prod_ext[ACC_W-1], sum_raw[ACC_W-1]);
        sum      = sum_raw;
        // On overflow both operands share a sign, so the accumulator sign
        // picks the rail to clamp to.
        if ((SATURATE != 0) && ovf) begin
            sum = ACC_W'(sat_bound(acc[ACC_W-1], ACC_W));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            cnt       <= '0;
            ovf_acc   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (step) begin
                if (tail_last) begin
                    // A load in the same edge as a pop overrides the clear above.
                    out_valid <= 1'b1;
                    out_data  <= sum;
                    out_count <= cnt + CNT_W'(1);
                    out_ovf   <= ovf_acc | ovf;
                    acc       <= '0;
                    cnt       <= '0;
                    ovf_acc   <= 1'b0;
                end else begin
                    acc     <= sum;
                    cnt     <= cnt + CNT_W'(1);
                    ovf_acc <= ovf_acc | ovf;
                end
            end
        end
    end

endmodule

// File: tb/tb_compute_engine_16_mac_feeder.sv
module tb_compute_engine_16_mac_feeder;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // ---------------- main instance (ACC_W=32, wrap) ----------------
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_act = '0;
    logic [7:0]  in_wgt = '0;
    logic        in_last = 1'b0;
    logic        mul_ce;
    logic [15:0] mul_din0;
    logic [7:0]  mul_din1;
    logic [23:0] mul_dout;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [15:0] out_count;
    logic        out_ovf;

    compute_engine_16_mac_feeder #(
        .MUL_LAT(3), .ACC_W(32), .SATURATE(0), .CNT_W(16)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_act(in_act), .in_wgt(in_wgt), .in_last(in_last),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    logic signed [23:0] ma0, ma1, ma2;
    always @(posedge clk) if (mul_ce) begin
        ma0 <= $signed(mul_din0) * $signed(mul_din1);
        ma1 <= ma0;
        ma2 <= ma1;
    end
    assign mul_dout = ma2;

    // ---------------- ACC_W=24 instances: saturating and wrapping ----------------
    logic        v4 = 1'b0;
    logic        l4 = 1'b0;
    logic [15:0] a4 = '0;
    logic [7:0]  w4 = '0;
    logic        rdy4 = 1'b1;

    logic        s_in_ready, s_ce, s_out_valid, s_out_ovf;
    logic [15:0] s_din0;
    logic [7:0]  s_din1;
    logic [23:0] s_dout, s_out_data;
    logic [15:0] s_out_count;

    compute_engine_16_mac_feeder #(
        .MUL_LAT(3), .ACC_W(24), .SATURATE(1), .CNT_W(16)
    ) dut_s (
        .clk(clk), .reset(reset),
        .in_valid(v4), .in_ready(s_in_ready), .in_act(a4), .in_wgt(w4), .in_last(l4),
        .mul_ce(s_ce), .mul_din0(s_din0), .mul_din1(s_din1), .mul_dout(s_dout),
        .out_valid(s_out_valid), .out_ready(rdy4), .out_data(s_out_data),
        .out_count(s_out_count), .out_ovf(s_out_ovf)
    );

    logic signed [23:0] sa0, sa1, sa2;
    always @(posedge clk) if (s_ce) begin
        sa0 <= $signed(s_din0) * $signed(s_din1);
        sa1 <= sa0;
        sa2 <= sa1;
    end
    assign s_dout = sa2;

    logic        w_in_ready, w_ce, w_out_valid, w_out_ovf;
    logic [15:0] w_din0;
    logic [7:0]  w_din1;
    logic [23:0] w_dout, w_out_data;
    logic [15:0] w_out_count;

    compute_engine_16_mac_feeder #(
        .MUL_LAT(3), .ACC_W(24), .SATURATE(0), .CNT_W(16)
    ) dut_w (
        .clk(clk), .reset(reset),
        .in_valid(v4), .in_ready(w_in_ready), .in_act(a4), .in_wgt(w4), .in_last(l4),
        .mul_ce(w_ce), .mul_din0(w_din0), .mul_din1(w_din1), .mul_dout(w_dout),
        .out_valid(w_out_valid), .out_ready(rdy4), .out_data(w_out_data),
        .out_count(w_out_count), .out_ovf(w_out_ovf)
    );

    logic signed [23:0] wa0, wa1, wa2;
    always @(posedge clk) if (w_ce) begin
        wa0 <= $signed(w_din0) * $signed(w_din1);
        wa1 <= wa0;
        wa2 <= wa1;
    end
    assign w_dout = wa2;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [31:0] data;
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t   sb[$];
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     rand_rdy = 1'b0;

    // Scoreboard: one result expected per vector, in order.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_data",  64'(out_data),  64'(e.data));
                check("sb_count", 64'(out_count), 64'(e.cnt));
                check("sb_ovf",   64'(out_ovf),   64'(e.ovf));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Drive one pair to the main instance and update the reference model.
    task automatic send(input int a, input int w, input bit l);
        bit got;
        in_act   = 16'(a);
        in_wgt   = 8'(w);
        in_last  = l;
        in_valid = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check("in_ready_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        m_acc += longint'(a) * longint'(w);
        m_cnt++;
        if (l) begin
            exp_t e;
            e.data = m_acc[31:0];
            e.cnt  = 16'(m_cnt);
            e.ovf  = 1'b0;
            sb.push_back(e);
            m_acc = 0;
            m_cnt = 0;
        end
    endtask

    initial begin
        longint wsum;
        int     budget;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_ovf",   64'(out_ovf),   64'd0);
        check("rst_mul_ce",    64'(mul_ce),    64'd1);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;

        // 1: (3,2) (-4,5) (100,-1) -> -114, out_valid exactly 3 edges after last accept
        send(3, 2, 1'b0);
        send(-4, 5, 1'b0);
        send(100, -1, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("t1_valid_early", 64'(out_valid), 64'd0);
        @(negedge clk);
        check("t1_valid_on_time", 64'(out_valid), 64'd1);
        check("t1_data", 64'(out_data), 64'hFFFF_FF8E);
        @(posedge clk);
        #1;

        // 2: single extreme pair
        send(-32768, -128, 1'b1);
        repeat (6) @(posedge clk);
        #1;

        // 3: back-to-back vectors with output held off
        out_ready = 1'b0;
        send(1, 1, 1'b0);
        send(2, 2, 1'b1);
        send(5, 5, 1'b1);
        budget = 0;
        while (!out_valid && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("t3_first_valid", 64'(out_valid), 64'd1);
        check("t3_in_ready_low", 64'(in_ready), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_hold_valid", 64'(out_valid), 64'd1);
            check("t3_hold_data",  64'(out_data),  64'd5);
            check("t3_hold_count", 64'(out_count), 64'd2);
            check("t3_hold_ready", 64'(in_ready),  64'd0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t3_drained", 64'(sb.size()), 64'd0);

        // 4: ACC_W=24 saturate vs wrap, 300 x (32767,127)
        a4 = 16'd32767;
        w4 = 8'd127;
        v4 = 1'b1;
        repeat (299) @(posedge clk);
        #1 l4 = 1'b1;
        @(posedge clk);
        #1;
        v4 = 1'b0;
        l4 = 1'b0;
        budget = 0;
        while (!s_out_valid && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        wsum = 64'd300 * 64'd4161409;
        check("t4_sat_valid", 64'(s_out_valid), 64'd1);
        check("t4_sat_data",  64'(s_out_data),  64'h7F_FFFF);
        check("t4_sat_ovf",   64'(s_out_ovf),   64'd1);
        check("t4_sat_count", 64'(s_out_count), 64'd300);
        check("t4_wrap_valid", 64'(w_out_valid), 64'd1);
        check("t4_wrap_data",  64'(w_out_data),  64'(wsum[23:0]));
        check("t4_wrap_ovf",   64'(w_out_ovf),   64'd1);
        check("t4_wrap_count", 64'(w_out_count), 64'd300);
        @(posedge clk);
        #1;

        // 5: random vectors, random input gaps and random out_ready
        rand_rdy = 1'b1;
        for (int v = 0; v < 1000; v++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int k = 0; k < len; k++) begin
                logic signed [15:0] ra;
                logic signed [7:0]  rw;
                ra = 16'($urandom);
                rw = 8'($urandom);
                if ($urandom_range(0, 1) == 1) begin
                    @(posedge clk);
                    #1;
                end
                send(int'(ra), int'(rw), k == len - 1);
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        budget = 0;
        while (sb.size() != 0 && budget < 2000) begin
            @(negedge clk);
            budget++;
        end
        check("t5_drained", 64'(sb.size()), 64'd0);
        @(posedge clk);
        #1;

        // 6: reset with two pairs in flight mid-vector
        send(11, 3, 1'b0);
        send(-9, 4, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_acc = 0;
        m_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t6_no_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(7, 3, 1'b1);
        budget = 0;
        while (!out_valid && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        check("t6_valid", 64'(out_valid), 64'd1);
        check("t6_data",  64'(out_data),  64'd21);
        check("t6_count", 64'(out_count), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        check("t6_drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
